// File: rtl/jtcps2_eeprom.sv
// jtcps2_eeprom: 93C46-class x16 serial EEPROM responder with NVRAM load/save port
module jtcps2_eeprom #(
   parameter int AW       = 6,
   parameter int DW       = 16,
   parameter int PROG_CYC = 1024
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sclk,
   input  logic          sdi,
   input  logic          scs,
   output logic          sdo,
   input  logic [AW-1:0] dump_addr,
   input  logic [DW-1:0] dump_din,
   input  logic          dump_we,
   output logic [DW-1:0] dump_dout,
   output logic          dump_flag
);
   localparam int CW = $clog2((DW > AW ? DW : AW) + 1);
   localparam int BW = $clog2(PROG_CYC + 1);

   typedef enum logic [2:0] {IDLE, OP, ADDR, RDATA, WDATA, WAITCS, PROG} state_t;

   state_t        state, state_n;
   logic          sclk_q, sclk_l, scs_q, sdi_q, rise;
   logic [1:0]    op;
   logic [AW-1:0] addr, addr_n, addr_inc;
   logic [DW-1:0] data;
   logic [CW-1:0] cnt;
   logic [BW-1:0] busy;
   logic          we_en, sdo_r, prog_kind, prog_go;
   logic [DW-1:0] mem [2**AW];

   assign rise     = sclk_q & ~sclk_l;
   assign addr_n   = {addr[AW-2:0], sdi_q};
   assign addr_inc = addr + 1'b1;

   // next-state decode; scs low aborts any command still being shifted in
   always_comb begin
      state_n   = state;
      prog_kind = op != 2'b00 || addr[AW-1 -: 2] == 2'b01 || addr[AW-1 -: 2] == 2'b10;
      case (state)
         IDLE:   if (rise && scs_q && sdi_q) state_n = OP;
         OP:     if (rise && cnt == CW'(1)) state_n = ADDR;
         ADDR:   if (rise && cnt == CW'(AW-1))
                    state_n = op == 2'b10 ? RDATA :
                              (op == 2'b01 || (op == 2'b00 && addr_n[AW-1 -: 2] == 2'b01)) ? WDATA : WAITCS;
         WDATA:  if (rise && cnt == CW'(DW-1)) state_n = WAITCS;
         WAITCS: if (!scs_q) state_n = (we_en && prog_kind) ? PROG : IDLE;
         PROG:   if (busy == '0) state_n = IDLE;
         default: state_n = state;
      endcase
      if (!scs_q && (state == OP || state == ADDR || state == RDATA || state == WDATA)) state_n = IDLE;
      prog_go = state == WAITCS && state_n == PROG;
   end

   // pin sampling, command shifting, read streaming and busy timer
   always_ff @(posedge clk) begin
      sclk_q <= sclk;
      sclk_l <= sclk_q;
      scs_q  <= scs;
      sdi_q  <= sdi;
      if (rst) begin
         sclk_q    <= 1'b0;
         sclk_l    <= 1'b0;
         scs_q     <= 1'b0;
         state     <= IDLE;
         we_en     <= 1'b0;
         busy      <= '0;
         dump_flag <= 1'b0;
         sdo_r     <= 1'b1;
         cnt       <= '0;
         op        <= '0;
         addr      <= '0;
         data      <= '0;
      end else begin
         state <= state_n;
         if (rise && scs_q) begin
            cnt <= (state_n != state || (state == RDATA && cnt == CW'(DW-1))) ? '0 : cnt + 1'b1;
            case (state)
               OP: op <= {op[0], sdi_q};
               ADDR: begin
                  addr <= addr_n;
                  if (state_n == RDATA) begin
                     data  <= mem[addr_n];
                     sdo_r <= 1'b0;
                  end
                  if (cnt == CW'(AW-1) && (op == 2'b11 || (op == 2'b00 && addr_n[AW-1 -: 2] == 2'b10)))
                     data <= '1;
                  if (cnt == CW'(AW-1) && op == 2'b00 && addr_n[AW-1 -: 2] == 2'b11) we_en <= 1'b1;
                  if (cnt == CW'(AW-1) && op == 2'b00 && addr_n[AW-1 -: 2] == 2'b00) we_en <= 1'b0;
               end
               RDATA: begin
                  sdo_r <= data[DW-1];
                  data  <= cnt == CW'(DW-1) ? mem[addr_inc] : data << 1;
                  if (cnt == CW'(DW-1)) addr <= addr_inc;
               end
               WDATA: data <= {data[DW-2:0], sdi_q};
               default: ;
            endcase
         end
         if (prog_go) begin
            busy      <= BW'(PROG_CYC);
            dump_flag <= 1'b1;
         end else if (state == PROG && busy != '0) begin
            busy <= busy - 1'b1;
         end
      end
   end

   // storage array: serial programming is applied after the dump write so it wins a collision
   always_ff @(posedge clk) begin
      if (dump_we) mem[dump_addr] <= dump_din;
      if (prog_go) begin
         if (op == 2'b00) for (int i = 0; i < 2**AW; i++) mem[i] <= data;
         else mem[addr] <= data;
      end
   end

   // registered dump read port
   always_ff @(posedge clk) begin
      if (rst) dump_dout <= '0;
      else dump_dout <= mem[dump_addr];
   end

   // serial output: ready/busy status or read data
   always_comb begin
      sdo = !scs_q ? 1'b1 : state == PROG ? 1'b0 : state == RDATA ? sdo_r : 1'b1;
   end
endmodule
